// File: rtl/clock_divider_bank_pkg.sv
// clock_divider_bank_pkg: mode encodings and default divider settings shared by the divider bank.
package clock_divider_bank_pkg;
   typedef enum logic [1:0] {
      MODE_STOP = 2'b00,
      MODE_RUN  = 2'b01,
      MODE_STEP = 2'b10
   } mode_t;
   localparam int CPU_CLK_DIV  = 49;
   localparam int CPU_CLK_HIGH = 25;
   localparam int STP_CLK_DIV  = 7;
endpackage

// File: rtl/clock_div_channel.sv
// clock_div_channel: one programmable divider with pending/active config, single-step and registered outputs.
module clock_div_channel
   import clock_divider_bank_pkg::*;
#(
   parameter int               CNT_W      = 32,
   parameter logic [CNT_W-1:0] RESET_DIV  = CNT_W'(CPU_CLK_DIV),
   parameter logic [CNT_W-1:0] RESET_HIGH = CNT_W'(CPU_CLK_HIGH),
   parameter logic [1:0]       RESET_MODE = MODE_RUN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [1:0]       cfg_mode,
   input  logic             step_req,
   output logic             clk_out,
   output logic             tick,
   output logic             step_busy
);
   logic [CNT_W-1:0] cnt, div_a, high_a, div_p, high_p, div_eff;
   logic [1:0]       mode_a, mode_p;
   logic             counting, at_end;

   always_comb begin
      div_eff  = (div_a == '0) ? CNT_W'(1) : div_a;
      counting = (mode_a == MODE_RUN) || (mode_a == MODE_STEP && step_busy);
      at_end   = counting && cnt == div_eff;
   end

   // an idle channel takes a write straight away; a running one only at its period boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         div_a     <= RESET_DIV;
         high_a    <= RESET_HIGH;
         mode_a    <= RESET_MODE;
         div_p     <= RESET_DIV;
         high_p    <= RESET_HIGH;
         mode_p    <= RESET_MODE;
         clk_out   <= 1'b0;
         tick      <= 1'b0;
         step_busy <= 1'b0;
      end else begin
         cnt       <= (counting && !at_end) ? cnt + 1'b1 : '0;
         clk_out   <= counting && cnt < high_a;
         tick      <= counting && cnt == '0;
         step_busy <= mode_a == MODE_STEP && (step_busy ? !at_end : step_req);
         if (cfg_we) begin
            div_p  <= cfg_div;
            high_p <= cfg_high;
            mode_p <= cfg_mode;
         end
         if (!counting) begin
            div_a  <= cfg_we ? cfg_div : div_p;
            high_a <= cfg_we ? cfg_high : high_p;
            mode_a <= cfg_we ? cfg_mode : mode_p;
         end else if (at_end) begin
            div_a  <= div_p;
            high_a <= high_p;
            mode_a <= mode_p;
         end
      end
   end
endmodule

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: NUM_CH independent programmable clock dividers with shared config-write decode.
module clock_divider_bank
   import clock_divider_bank_pkg::*;
#(
   parameter int               NUM_CH     = 4,
   parameter int               CNT_W      = 32,
   parameter logic [CNT_W-1:0] RESET_DIV  = CNT_W'(CPU_CLK_DIV),
   parameter logic [CNT_W-1:0] RESET_HIGH = CNT_W'(CPU_CLK_HIGH),
   parameter logic [1:0]       RESET_MODE = MODE_RUN,
   localparam int              CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic [1:0]        cfg_mode,
   input  logic [NUM_CH-1:0] step_req,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] step_busy
);
   // channel numbers at or above NUM_CH match no instance, so such writes drop out
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clock_div_channel #(
         .CNT_W(CNT_W),
         .RESET_DIV(RESET_DIV),
         .RESET_HIGH(RESET_HIGH),
         .RESET_MODE(RESET_MODE)
      ) u_ch (
         .clk(clk),
         .reset(reset),
         .cfg_we(cfg_we && cfg_ch == CH_W'(i)),
         .cfg_div(cfg_div),
         .cfg_high(cfg_high),
         .cfg_mode(cfg_mode),
         .step_req(step_req[i]),
         .clk_out(clk_out[i]),
         .tick(tick[i]),
         .step_busy(step_busy[i])
      );
   end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed checks of period, duty, reprogramming, single-step, stop and reset.
module tb_clock_divider_bank;
   import clock_divider_bank_pkg::*;
   localparam int NCH = 3;
   logic           clk = 1'b0, reset = 1'b1, cfg_we = 1'b0;
   logic [1:0]     cfg_ch = '0, cfg_mode = '0;
   logic [31:0]    cfg_div = '0, cfg_high = '0;
   logic [NCH-1:0] step_req = '0;
   logic [NCH-1:0] clk_out, tick, step_busy;
   int n_cmp = 0, n_bad = 0;
   int n_tick, n_high, n_busy, first_tick, idx, cur_run, min_run, max_run;

   always #5 clk = ~clk;

   clock_divider_bank #(.NUM_CH(NCH)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_mode(cfg_mode),
      .step_req(step_req), .clk_out(clk_out), .tick(tick), .step_busy(step_busy)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_tick = 0; n_high = 0; n_busy = 0; first_tick = -1; idx = 0;
      cur_run = 0; min_run = 9999; max_run = 0;
   endtask

   task automatic cycles(input int n, input int ch);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         idx++;
         n_tick += int'(tick[ch]);
         n_high += int'(clk_out[ch]);
         n_busy += int'(step_busy[ch]);
         if (tick[ch] && first_tick < 0) first_tick = idx;
         if (clk_out[ch]) cur_run++;
         else if (cur_run > 0) begin
            if (cur_run < min_run) min_run = cur_run;
            if (cur_run > max_run) max_run = cur_run;
            cur_run = 0;
         end
      end
   endtask

   task automatic cfg(input int ch, input int div, input int high, input logic [1:0] mode);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = 32'(div); cfg_high = 32'(high); cfg_mode = mode;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic step(input int ch, input string tag);
      step_req[ch] = 1'b1;
      @(negedge clk);
      step_req[ch] = 1'b0;
      check(tag, int'(step_busy[ch]), 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_clk_out", int'(clk_out), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_busy", int'(step_busy), 0);
      reset = 1'b0;
      clr(); cycles(100, 0);
      check("def_first_tick", first_tick, 1);
      check("def_ticks", n_tick, 2);
      check("def_highs", n_high, 50);
      check("def_min_run", min_run, 25);
      check("def_max_run", max_run, 25);
      // reprogram ch1 mid-period: old period must finish untouched
      cycles(10, 1);
      cfg(1, 3, 2, MODE_RUN);
      clr(); cycles(39, 1);
      check("reprog_old_ticks", n_tick, 0);
      check("reprog_old_highs", n_high, 14);
      clr(); cycles(40, 1);
      check("reprog_first_tick", first_tick, 1);
      check("reprog_ticks", n_tick, 10);
      check("reprog_highs", n_high, 20);
      check("reprog_min_run", min_run, 2);
      check("reprog_max_run", max_run, 2);
      // duty extremes on ch2
      cfg(2, 0, 1, MODE_RUN);
      clr(); cycles(20, 2);
      clr(); cycles(20, 2);
      check("div0_ticks", n_tick, 10);
      check("div0_highs", n_high, 10);
      check("div0_min_run", min_run, 1);
      check("div0_max_run", max_run, 1);
      cfg(2, 0, 0, MODE_RUN);
      clr(); cycles(4, 2);
      clr(); cycles(20, 2);
      check("high0_ticks", n_tick, 10);
      check("high0_highs", n_high, 0);
      cfg(2, 4, 10, MODE_RUN);
      clr(); cycles(4, 2);
      clr(); cycles(20, 2);
      check("highbig_ticks", n_tick, 4);
      check("highbig_highs", n_high, 20);
      // single step on ch0
      cfg(0, 7, 4, MODE_STEP);
      clr(); cycles(60, 0);
      clr(); cycles(5, 0);
      check("step_idle_ticks", n_tick, 0);
      check("step_idle_highs", n_high, 0);
      check("step_idle_busy", n_busy, 0);
      clr(); step(0, "step1_set");
      cycles(3, 0);
      step_req[0] = 1'b1;
      cycles(1, 0);
      step_req[0] = 1'b0;
      cycles(20, 0);
      check("step1_busy", n_busy, 7);
      check("step1_ticks", n_tick, 1);
      check("step1_highs", n_high, 4);
      check("step1_max_run", max_run, 4);
      clr(); step(0, "step2_set");
      cycles(20, 0);
      check("step2_busy", n_busy, 7);
      check("step2_ticks", n_tick, 1);
      check("step2_highs", n_high, 4);
      // STOP on ch1, then a write to a channel that does not exist
      cfg(1, 3, 2, MODE_STOP);
      clr(); cycles(4, 1);
      clr(); cycles(10, 1);
      check("stop_ticks", n_tick, 0);
      check("stop_highs", n_high, 0);
      cfg(3, 0, 1, MODE_RUN);
      clr(); cycles(10, 1);
      check("oor_ch1_ticks", n_tick, 0);
      clr(); cycles(10, 0);
      check("oor_ch0_ticks", n_tick, 0);
      check("oor_ch0_busy", n_busy, 0);
      clr(); cycles(20, 2);
      check("oor_ch2_ticks", n_tick, 4);
      check("oor_ch2_highs", n_high, 20);
      // asynchronous reset with ch0 mid-high and ch2 mid-step
      cfg(0, 49, 25, MODE_RUN);
      cfg(2, 7, 4, MODE_STEP);
      clr(); cycles(6, 2);
      step(2, "pre_rst_busy_set");
      cycles(2, 2);
      check("pre_rst_ch0_high", int'(clk_out[0]), 1);
      check("pre_rst_ch2_busy", int'(step_busy[2]), 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_clk_out", int'(clk_out), 0);
      check("async_rst_tick", int'(tick), 0);
      check("async_rst_busy", int'(step_busy), 0);
      @(negedge clk);
      reset = 1'b0;
      clr(); cycles(100, 0);
      check("post_rst_first_tick", first_tick, 1);
      check("post_rst_ticks", n_tick, 2);
      check("post_rst_highs", n_high, 50);
      check("post_rst_min_run", min_run, 25);
      check("post_rst_max_run", max_run, 25);
      clr(); cycles(100, 2);
      check("post_rst_ch2_ticks", n_tick, 2);
      check("post_rst_ch2_highs", n_high, 50);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
